// File: rtl/gencol_pkg.sv
// Shared types, constants and the reference column function for the gencol family.
package gencol_pkg;

    localparam int unsigned DEF_MAXLOG = 2;
    localparam int unsigned MAXSTRIDE  = 2 ** DEF_MAXLOG;
    localparam int unsigned MAXW       = 1024;

    typedef logic [9:0] widx_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Column j of the Toeplitz matrix with first row row0 and first column col0; bits >= l are zero.
    function automatic logic [MAXW-1:0] toeplitz_col(input logic [MAXW-1:0] row0,
                                                     input logic [MAXW-1:0] col0,
                                                     input int unsigned     j,
                                                     input int unsigned     l);
        logic [MAXW-1:0] res;
        res = '0;
        for (int unsigned i = 0; i < l; i++) begin
            res[widx_t'(i)] = (i >= j) ? col0[widx_t'(i - j)] : row0[widx_t'(j - i)];
        end
        return res;
    endfunction

endpackage

// File: rtl/gencol_shift_insert.sv
// Advances a Toeplitz column by 2**slog_i rows, feeding new first-row bits in at the bottom.
module gencol_shift_insert
    import gencol_pkg::*;
#(
    parameter  int unsigned L      = 128,
    parameter  int unsigned MAXLOG = 2,
    localparam int unsigned MSTR   = 2 ** MAXLOG,
    localparam int unsigned SW     = $clog2(MAXLOG + 1)
) (
    input  logic [L-1:0]    col_i,
    input  logic [MSTR-1:0] row_lo_i,
    input  logic [SW-1:0]   slog_i,
    output logic [L-1:0]    nxt_o
);

    // row_lo_i[0] is the nearest row bit, so it lands highest in the inserted field.
    always_comb begin
        nxt_o = col_i;
        for (int unsigned k = 0; k <= MAXLOG; k++) begin
            if (32'(slog_i) == k) begin
                nxt_o = col_i << (2 ** k);
                for (int unsigned b = 0; b < 2 ** k; b++) begin
                    nxt_o[b] = row_lo_i[(2 ** k) - 1 - b];
                end
            end
        end
    end

endmodule

// File: rtl/gencol_stream.sv
// Streaming Toeplitz column generator: seed in via valid/ready, columns out every S with backpressure.
module gencol_stream
    import gencol_pkg::*;
#(
    parameter  int unsigned BS     = 64,
    parameter  int unsigned N      = 256,
    parameter  int unsigned L      = 128,
    parameter  int unsigned MAXLOG = DEF_MAXLOG,
    localparam int unsigned SW     = $clog2(MAXLOG + 1),
    localparam int unsigned IW     = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          seed_valid,
    output logic          seed_ready,
    input  logic [N-1:0]  row_in,
    input  logic [L-1:0]  col_in,
    input  logic [SW-1:0] stride_log2,
    input  logic          abort,
    output logic          col_valid,
    input  logic          col_ready,
    output logic [L-1:0]  col,
    output logic [IW-1:0] col_idx,
    output logic          col_last
);

    localparam int unsigned MSTR = 2 ** MAXLOG;

    if ((N % BS) != 0 || (L % BS) != 0 || (N % MSTR) != 0 || MSTR >= L) begin : g_param_check
        $error("gencol_stream: invalid parameter combination");
    end

    state_e        state_q, state_d;
    logic [N-1:0]  row_q, row_d;
    logic [SW-1:0] slog_q, slog_d;
    logic [L-1:0]  col_q, col_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          rdy_q, rdy_d;
    logic          vld_q, vld_d;

    logic [IW-1:0] step;
    logic [L-1:0]  nxt_col;
    logic          is_last;

    assign step    = IW'(1) << slog_q;
    assign is_last = (({1'b0, idx_q} + {1'b0, step}) == (IW + 1)'(N));

    gencol_shift_insert #(
        .L      (L),
        .MAXLOG (MAXLOG)
    ) u_shift_insert (
        .col_i    (col_q),
        .row_lo_i (row_q[MSTR-1:0]),
        .slog_i   (slog_q),
        .nxt_o    (nxt_col)
    );

    // row_q is kept aligned so that row0[j+1] always sits at bit 0.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        slog_d  = slog_q;
        col_d   = col_q;
        idx_d   = idx_q;
        rdy_d   = rdy_q;
        vld_d   = vld_q;
        case (state_q)
            IDLE: begin
                if (seed_valid) begin
                    state_d = RUN;
                    row_d   = row_in >> 1;
                    slog_d  = (32'(stride_log2) > MAXLOG) ? SW'(MAXLOG) : stride_log2;
                    col_d   = col_in;
                    idx_d   = '0;
                    rdy_d   = 1'b0;
                    vld_d   = 1'b1;
                end
            end
            RUN: begin
                if (abort || (col_ready && is_last)) begin
                    state_d = IDLE;
                    rdy_d   = 1'b1;
                    vld_d   = 1'b0;
                end else if (col_ready) begin
                    col_d = nxt_col;
                    idx_d = idx_q + step;
                    row_d = row_q >> step;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            slog_q  <= '0;
            col_q   <= '0;
            idx_q   <= '0;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            slog_q  <= slog_d;
            col_q   <= col_d;
            idx_q   <= idx_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
        end
    end

    assign seed_ready = rdy_q;
    assign col_valid  = vld_q;
    assign col        = col_q;
    assign col_idx    = idx_q;
    assign col_last   = vld_q & is_last;

endmodule
